// File: rtl/counter_pkg.sv
// ---------------------------------------------------------------------------
// counter_pkg: shared constants and helpers for the up/down modulo counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Ceiling log2; clog2(1) returns 0, so callers clamp widths to at least 1.
  function automatic int clog2(input int value);
    int res;
    res = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << res) < 64'(value)) res = res + 1;
    end
    return res;
  endfunction

endpackage

`default_nettype wire

// File: rtl/counter_prescaler.sv
// ---------------------------------------------------------------------------
// counter_prescaler: emits one tick per PRESCALE enabled cycles; clr restarts it.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  import counter_pkg::*;

  localparam int            CW   = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    tick  = en & ~clr & (cnt_q == LAST);
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/updown_mod_counter.sv
// ---------------------------------------------------------------------------
// updown_mod_counter: up/down modulo counter with wrap/saturate, tc and sticky ovf.
// Optional COUNTER_PRESCALE_EN gates steps through a PRESCALE divider. Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module updown_mod_counter #(
  parameter int WIDTH    = 8,
  parameter int MODULUS  = 256,
`ifdef COUNTER_PRESCALE_EN
  parameter int SATURATE = 0,
  parameter int PRESCALE = 4
`else
  parameter int SATURATE = 0
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step;
  logic             boundary;
  logic [WIDTH-1:0] load_clamped;

`ifdef COUNTER_PRESCALE_EN
  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (load),
    .tick(step)
  );
`else
  assign step = en;
`endif

  assign load_clamped = ({1'b0, load_val} >= MOD_EXT) ? MAX_VAL : load_val;

  always_comb begin
    count_d  = count_q;
    boundary = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (step) begin
      if (up == DIR_UP) begin
        if (count_q == MAX_VAL) begin
          boundary = 1'b1;
          count_d  = (SATURATE == MODE_SAT) ? MAX_VAL : '0;
        end else begin
          count_d = count_q + WIDTH'(1);
        end
      end else begin
        if (count_q == '0) begin
          boundary = 1'b1;
          count_d  = (SATURATE == MODE_SAT) ? '0 : MAX_VAL;
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end
    // Set beats clear when both land in the same cycle.
    tc_d  = boundary;
    ovf_d = boundary | (ovf_q & ~clr_ovf);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

`default_nettype wire
